fg_dac_serializer: RTL and testbench

- Output stage of the function generator.
- Takes the final signed sample produced by the select/offset/enable stage and shifts it to an external SPI DAC as a frame of command bits plus data bits.
- Owns the chip-select, serial clock and data lines; upstream sees a valid/ready handshake.

---
 rtl/fg_pkg.sv | 18 +
 rtl/fg_sclk_gen.sv | 40 ++++
 rtl/fg_dac_serializer.sv | 161 ++++++++++++++++
 tb/tb_fg_dac_serializer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/fg_pkg.sv
// Shared definitions for the function-generator DAC output path: state encoding,
// default DAC command prefix and counter sizing helper.
package fg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2,
    ST_GAP   = 2'd3
  } fg_state_t;

  localparam logic [7:0] CMD_WORD_DEF = 8'h30;

  function automatic int unsigned cnt_width(input int unsigned div);
    return $clog2(div + 1);
  endfunction

endpackage

// File: rtl/fg_sclk_gen.sv
// SPI serial clock generator: CLK_DIV cycles per half-period, idle low, count restarts
// whenever en is deasserted; rise/fall are single-cycle ticks preceding the sclk toggle.
module fg_sclk_gen
  import fg_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam int unsigned CW = cnt_width(CLK_DIV);

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap = en && (cnt == CW'(CLK_DIV - 1));
  assign rise = wrap && !sclk;
  assign fall = wrap && sclk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (!en) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (wrap) begin
      cnt  <= '0;
      sclk <= ~sclk;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fg_dac_serializer.sv
// SPI DAC output stage: frames {CMD_WORD, sample} MSB first in SPI mode 0 behind a valid/ready input.
// Define FG_DAC_OFFSET_BINARY_EN to invert the sample MSB (two's complement -> offset binary).
module fg_dac_serializer
  import fg_pkg::*;
#(
  parameter int unsigned BITWIDTH = 16,
  parameter int unsigned CMD_BITS = 8,
  parameter logic [((CMD_BITS > 0) ? CMD_BITS : 1)-1:0] CMD_WORD = CMD_WORD_DEF,
  parameter int unsigned CLK_DIV  = 2
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       enable_i,
  input  logic signed [BITWIDTH-1:0] data_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  output logic                       cs_n_o,
  output logic                       sclk_o,
  output logic                       mosi_o,
  output logic                       done_o
);

  localparam int unsigned N   = CMD_BITS + BITWIDTH;
  localparam int unsigned BCW = $clog2(N + 1);
  localparam int unsigned PCW = cnt_width(CLK_DIV);

  fg_state_t            state, state_nxt;
  logic [N-1:0]         shreg, shreg_nxt;
  logic [BCW-1:0]       bit_cnt, bit_cnt_nxt;
  logic [PCW-1:0]       ph_cnt, ph_cnt_nxt;
  logic                 cs_n_q, cs_n_nxt;
  logic                 mosi_q, mosi_nxt;
  logic                 done_q, done_nxt;
  logic                 live;
  logic                 accept;
  logic                 sck_rise, sck_fall;
  logic [BITWIDTH-1:0]  sample;
  logic [N-1:0]         frame;

  always_comb begin
    sample = data_i;
`ifdef FG_DAC_OFFSET_BINARY_EN
    sample[BITWIDTH-1] = ~data_i[BITWIDTH-1];
`endif
  end

  generate
    if (CMD_BITS > 0) begin : g_cmd
      assign frame = {CMD_WORD[CMD_BITS-1:0], sample};
    end else begin : g_nocmd
      assign frame = sample;
    end
  endgenerate

  // live keeps ready low during reset and for the first edge after release
  assign ready_o = live && (state == ST_IDLE) && enable_i;
  assign accept  = valid_i && ready_o;
  assign cs_n_o  = cs_n_q;
  assign mosi_o  = mosi_q;
  assign done_o  = done_q;

  fg_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk   (clk_i),
    .rst_n (rstn_i),
    .en    (state == ST_SHIFT),
    .sclk  (sclk_o),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    ph_cnt_nxt  = ph_cnt;
    cs_n_nxt    = cs_n_q;
    mosi_nxt    = mosi_q;
    done_nxt    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt   = ST_SHIFT;
          shreg_nxt   = frame;
          bit_cnt_nxt = '0;
          cs_n_nxt    = 1'b0;
          mosi_nxt    = frame[N-1];
        end
      end
      ST_SHIFT: begin
        // bits are counted on the rise and advanced on the fall so mosi never moves while sclk is high
        if (sck_rise) begin
          bit_cnt_nxt = bit_cnt + 1'b1;
        end
        if (sck_fall) begin
          if (bit_cnt == BCW'(N)) begin
            state_nxt  = ST_HOLD;
            mosi_nxt   = 1'b0;
            ph_cnt_nxt = '0;
          end else begin
            shreg_nxt = shreg << 1;
            mosi_nxt  = shreg[N-2];
          end
        end
      end
      ST_HOLD: begin
        if (ph_cnt == PCW'(CLK_DIV - 1)) begin
          state_nxt  = ST_GAP;
          ph_cnt_nxt = '0;
          cs_n_nxt   = 1'b1;
          done_nxt   = 1'b1;
        end else begin
          ph_cnt_nxt = ph_cnt + 1'b1;
        end
      end
      ST_GAP: begin
        if (ph_cnt == PCW'(CLK_DIV - 1)) begin
          state_nxt  = ST_IDLE;
          ph_cnt_nxt = '0;
        end else begin
          ph_cnt_nxt = ph_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cs_n_nxt  = 1'b1;
        mosi_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      shreg   <= '0;
      bit_cnt <= '0;
      ph_cnt  <= '0;
      cs_n_q  <= 1'b1;
      mosi_q  <= 1'b0;
      done_q  <= 1'b0;
      live    <= 1'b0;
    end else begin
      shreg   <= shreg_nxt;
      bit_cnt <= bit_cnt_nxt;
      ph_cnt  <= ph_cnt_nxt;
      cs_n_q  <= cs_n_nxt;
      mosi_q  <= mosi_nxt;
      done_q  <= done_nxt;
      live    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fg_dac_serializer.sv
// Directed bench for fg_dac_serializer: decodes SPI frames on the pins and compares against hand-computed words.
module tb_fg_dac_serializer;

  logic        clk    = 1'b0;
  logic        rstn   = 1'b0;
  logic        enable = 1'b0;
  logic        valid  = 1'b0;
  logic [15:0] data   = 16'h0000;
  wire         ready, cs_n, sclk, mosi, done;

  fg_dac_serializer #(
    .BITWIDTH (16),
    .CMD_BITS (8),
    .CMD_WORD (8'h30),
    .CLK_DIV  (2)
  ) dut (
    .clk_i    (clk),
    .rstn_i   (rstn),
    .enable_i (enable),
    .data_i   (data),
    .valid_i  (valid),
    .ready_o  (ready),
    .cs_n_o   (cs_n),
    .sclk_o   (sclk),
    .mosi_o   (mosi),
    .done_o   (done)
  );

  always #5 clk = ~clk;

`ifdef FG_DAC_OFFSET_BINARY_EN
  localparam logic [23:0] EXP_ZERO = 24'h308000;
  localparam logic [23:0] EXP_NEG  = 24'h300000;
  localparam logic [23:0] EXP_POS  = 24'h30FFFF;
  localparam logic [23:0] EXP_A    = 24'h309234;
  localparam logic [23:0] EXP_B    = 24'h307EDC;
  localparam logic [23:0] EXP_C    = 24'h3025C3;
  localparam logic [23:0] EXP_E    = 24'h304001;
`else
  localparam logic [23:0] EXP_ZERO = 24'h300000;
  localparam logic [23:0] EXP_NEG  = 24'h308000;
  localparam logic [23:0] EXP_POS  = 24'h307FFF;
  localparam logic [23:0] EXP_A    = 24'h301234;
  localparam logic [23:0] EXP_B    = 24'h30FEDC;
  localparam logic [23:0] EXP_C    = 24'h30A5C3;
  localparam logic [23:0] EXP_E    = 24'h30C001;
`endif

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // pin-level frame decoder
  logic        prev_sclk = 1'b0;
  logic        prev_cs   = 1'b1;
  logic        prev_mosi = 1'b0;
  logic        cs_rise;
  logic [23:0] cap       = '0;
  int          nb        = 0;
  int          cs_run    = 0;
  int          last_gap  = 0;
  int          done_cnt  = 0;
  logic [23:0] fq[$];

  always @(negedge clk) begin
    if (!rstn) begin
      cap       = '0;
      nb        = 0;
      cs_run    = 0;
      prev_sclk = 1'b0;
      prev_cs   = 1'b1;
      prev_mosi = 1'b0;
    end else begin
      cs_rise = cs_n && !prev_cs;
      if (done || cs_rise) chk("done_at_cs_rise", {31'd0, done}, {31'd0, cs_rise});
      if (done) done_cnt++;
      if (sclk && !prev_sclk) begin
        chk("mosi_stable", {31'd0, mosi}, {31'd0, prev_mosi});
        cap = {cap[22:0], mosi};
        nb++;
      end
      if (cs_rise) begin
        chk("frame_bits", nb, 24);
        fq.push_back(cap);
        nb = 0;
      end
      if (cs_n) begin
        cs_run++;
      end else if (prev_cs) begin
        last_gap = cs_run;
        cs_run   = 0;
      end
      prev_sclk = sclk;
      prev_cs   = cs_n;
      prev_mosi = mosi;
    end
  end

  // call at a negedge; returns just after the accepting posedge with valid still high
  task automatic accept(input logic [15:0] d);
    int k;
    data  = d;
    valid = 1'b1;
    k = 0;
    while (!ready && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (!ready) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
  endtask

  task automatic send(input logic [15:0] d);
    accept(d);
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic wait_frame(output logic [23:0] f);
    int k;
    k = 0;
    while (fq.size() == 0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (fq.size() == 0) begin
      chk("frame_timeout", 32'd0, 32'd1);
      f = '0;
    end else begin
      f = fq.pop_front();
    end
  endtask

  task automatic wait_bits(input int n);
    int k;
    k = 0;
    while (nb < n && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (nb < n) chk("bits_timeout", nb, n);
  endtask

  initial begin
    logic [23:0] f;
    int          n;
    int          dc0;

    enable = 1'b1;
    rstn   = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_cs_n",  {31'd0, cs_n},  32'd1);
    chk("reset_sclk",  {31'd0, sclk},  32'd0);
    chk("reset_mosi",  {31'd0, mosi},  32'd0);
    chk("reset_ready", {31'd0, ready}, 32'd0);
    chk("reset_done",  {31'd0, done},  32'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {31'd0, ready}, 32'd1);

    // zero sample with accept-to-ready latency
    dc0 = done_cnt;
    send(16'h0000);
    n = 1;
    while (!ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("ready_return", n, 101);
    wait_frame(f);
    chk("frame_zero", {8'd0, f}, {8'd0, EXP_ZERO});
    chk("done_once", done_cnt - dc0, 1);

    send(16'h8000);
    wait_frame(f);
    chk("frame_neg_full", {8'd0, f}, {8'd0, EXP_NEG});
    @(negedge clk);
    send(16'h7FFF);
    wait_frame(f);
    chk("frame_pos_full", {8'd0, f}, {8'd0, EXP_POS});

    // back-to-back with valid held high across both samples
    @(negedge clk);
    accept(16'h1234);
    @(negedge clk);
    accept(16'hFEDC);
    @(negedge clk);
    valid = 1'b0;
    wait_frame(f);
    chk("b2b_frame_a", {8'd0, f}, {8'd0, EXP_A});
    wait_frame(f);
    chk("b2b_frame_b", {8'd0, f}, {8'd0, EXP_B});
    chk("b2b_cs_high_gap", last_gap, 3);
    repeat (150) @(negedge clk);
    chk("b2b_no_extra", fq.size(), 0);

    // enable dropped mid-frame
    send(16'hA5C3);
    wait_bits(10);
    enable = 1'b0;
    wait_frame(f);
    chk("en_drop_frame", {8'd0, f}, {8'd0, EXP_C});
    repeat (10) @(negedge clk);
    chk("en_drop_ready_low", {31'd0, ready}, 32'd0);
    enable = 1'b1;
    @(negedge clk);
    chk("en_restore_ready", {31'd0, ready}, 32'd1);

    // reset mid-frame
    send(16'h5555);
    wait_bits(12);
    rstn = 1'b0;
    #1;
    chk("midrst_cs_n",  {31'd0, cs_n},  32'd1);
    chk("midrst_sclk",  {31'd0, sclk},  32'd0);
    chk("midrst_mosi",  {31'd0, mosi},  32'd0);
    chk("midrst_ready", {31'd0, ready}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("midrst_partial_dropped", fq.size(), 0);
    send(16'hC001);
    wait_frame(f);
    chk("frame_after_reset", {8'd0, f}, {8'd0, EXP_E});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
